ins_fetcher: RTL and testbench
==============================

Name: ins_fetcher

Overview:
- Front-end stage directly upstream of the decoder. Holds the PC and fetches 32-bit instruction words through a small direct-mapped instruction cache, or from the memory controller on a miss.
- Presents one instruction at a time to the decoder and holds it while the decoder stalls.
- Takes the decoder's next_PC on consumption and is redirected by the ROB on a clear.

Parameters:
RESET_PC, 32'h0, PC loaded on reset
ICACHE_IDX_BIT, 6, log2 of cache lines; one 32-bit word per line

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset
rdy_in  in  1  global ready; low freezes all state
dec_stall  in  1  decoder stall; instruction is not consumed this cycle
dec_next_pc  in  32  PC of the next instruction, computed by the decoder
inst_valid  out  1  inst/inst_addr valid; drives the decoder's inst_input
inst  out  32  instruction word
inst_addr  out  32  address of inst
rob_clear  in  1  mispredict flush
rob_clear_pc  in  32  redirect target on flush
mem_req  out  1  instruction-fetch request to the memory controller
mem_addr  out  32  word address of the request
mem_ready  in  1  mem_data valid; one-cycle pulse
mem_data  in  32  fetched word

Behaviour:
- Reset: rst_in is asynchronous and active-high; clock is clk_in. On reset: pc=RESET_PC, state=FETCH, inst_valid=0, inst=0, inst_addr=0, mem_req=0, mem_addr=0, all cache valid bits=0.
- rdy_in=0: no register or cache state changes, and mem_ready is ignored.
- State FETCH: cache lookup on pc (index pc[ICACHE_IDX_BIT+1:2], tag pc[31:ICACHE_IDX_BIT+2]).
  - Hit: inst<=line, inst_addr<=pc, inst_valid<=1, go to HOLD.
  - Miss: mem_req<=1, mem_addr<=pc, go to WAIT.
- State WAIT: mem_req stays high until mem_ready. On mem_ready:
  - write the line (valid, tag, data);
  - inst<=mem_data, inst_addr<=pc, inst_valid<=1;
  - mem_req<=0, go to HOLD.
- State HOLD:
  - dec_stall=1: inst, inst_addr and inst_valid stay stable.
  - dec_stall=0: the instruction is consumed at this edge; inst_valid<=0, pc<=dec_next_pc, go to FETCH.
- Latency:
  - Hit: inst_valid rises 2 edges after consumption, giving a throughput of 1 instruction per 2 cycles.
  - Miss: inst_valid rises 1 edge after mem_ready.
- rob_clear has the highest priority, in any state: inst_valid<=0, pc<=rob_clear_pc.
  - From FETCH or HOLD: go to FETCH; any mem_req a FETCH-miss would have raised this edge is not raised.
  - From WAIT without mem_ready: go to DRAIN with mem_req held high.
  - From WAIT with mem_ready in the same cycle: fill the cache, discard the data, mem_req<=0, go to FETCH.
- State DRAIN:
  - On mem_ready: fill the cache with the returned word (at mem_addr), discard it, mem_req<=0, go to FETCH.
  - A second rob_clear while in DRAIN only updates pc.
- mem_addr is stable while mem_req=1, and the request never changes until mem_ready.
- The cache is never invalidated except by reset; instruction memory is read-only.

Decomposition:
- Shared package/Config: RESET_PC default and fetcher state encodings FETCH/WAIT/HOLD/DRAIN (2 bits).
- Sub-module icache:
  - combinational lookup (hit, data) on an address;
  - synchronous write port (we, addr, data);
  - valid-bit array cleared on rst_in.
- ins_fetcher contains the FSM, PC and output registers.

Test Plan:
- Reset, mem returns 32'h00000013 for addr 0 after 3 cycles -> mem_req=1, mem_addr=0; inst_valid=1, inst=32'h13, inst_addr=0 one edge after mem_ready.
- Hold with dec_stall=1 for 5 cycles, then dec_stall=0, dec_next_pc=4 -> inst stable throughout; next mem_req with mem_addr=4.
- Re-fetch addr 0 after it is cached (dec_next_pc=0) -> no mem_req; inst_valid=1, inst=32'h13 two edges after consumption.
- rob_clear with rob_clear_pc=32'h100 during WAIT for addr 8 -> DRAIN keeps mem_req/mem_addr=8 until mem_ready; that data is never presented (inst_valid stays 0); then mem_req with mem_addr=32'h100.
- rob_clear and mem_ready in the same cycle -> data discarded but cached (later fetch of that addr hits); next request is rob_clear_pc.
- rdy_in=0 for 4 cycles mid-WAIT with a mem_ready pulse -> no state change, pulse ignored; rst_in asserted mid-WAIT -> all outputs 0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/ins_fetcher_pkg.sv
// Shared configuration and state encoding for the instruction fetch stage.
package ins_fetcher_pkg;

  localparam logic [31:0] DEF_RESET_PC       = 32'h0000_0000;
  localparam int unsigned DEF_ICACHE_IDX_BIT = 6;
  localparam int unsigned WORD_W             = 32;
  localparam int unsigned FETCH_STATE_W      = 2;

  typedef enum logic [FETCH_STATE_W-1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ins_fetcher_icache.sv
// Direct-mapped instruction cache, one word per line: combinational lookup,
// synchronous fill, valid bits cleared only by reset.
module ins_fetcher_icache
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned IDX_BIT = DEF_ICACHE_IDX_BIT
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [IDX_BIT-1:0]          rd_idx,
  input  logic [WORD_W-IDX_BIT-3:0]   rd_tag,
  output logic                        hit_c,
  output logic [WORD_W-1:0]           rd_data_c,
  input  logic                        we,
  input  logic [IDX_BIT-1:0]          wr_idx,
  input  logic [WORD_W-IDX_BIT-3:0]   wr_tag,
  input  logic [WORD_W-1:0]           wr_data
);

  localparam int unsigned LINES = 1 << IDX_BIT;
  localparam int unsigned TAG_W = WORD_W - IDX_BIT - 2;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES];

  // Valid bits are the only cache state that needs a reset value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign hit_c     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data_c = data_mem[rd_idx];

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetch stage: PC, icache lookup, miss handling toward the memory
// controller, and a one-entry instruction holding register for the decoder.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEF_RESET_PC,
  parameter int unsigned ICACHE_IDX_BIT = DEF_ICACHE_IDX_BIT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        dec_stall,
  input  logic [31:0] dec_next_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int unsigned IDX_HI = ICACHE_IDX_BIT + 1;
  localparam int unsigned TAG_W  = WORD_W - ICACHE_IDX_BIT - 2;

  fetch_state_e      state;
  logic [31:0]       pc;
  logic              hit_c;
  logic [WORD_W-1:0] line_c;
  logic              fill_c;

  // Any returned word is cached, whether presented or discarded by a flush.
  assign fill_c = rdy_in && mem_ready && ((state == WAIT) || (state == DRAIN));

  ins_fetcher_icache #(
    .IDX_BIT (ICACHE_IDX_BIT)
  ) u_icache (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_idx    (pc[IDX_HI:2]),
    .rd_tag    (pc[31:IDX_HI+1]),
    .hit_c     (hit_c),
    .rd_data_c (line_c),
    .we        (fill_c),
    .wr_idx    (mem_addr[IDX_HI:2]),
    .wr_tag    (TAG_W'(mem_addr[31:IDX_HI+1])),
    .wr_data   (mem_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_addr  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        // Flush: an outstanding request must still complete before refetching.
        inst_valid <= 1'b0;
        pc         <= rob_clear_pc;
        case (state)
          FETCH, HOLD: state <= FETCH;
          WAIT, DRAIN: begin
            if (mem_ready) begin
              mem_req <= 1'b0;
              state   <= FETCH;
            end else begin
              state   <= DRAIN;
            end
          end
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (hit_c) begin
              inst       <= line_c;
              inst_addr  <= pc;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (mem_ready) begin
              inst       <= mem_data;
              inst_addr  <= pc;
              inst_valid <= 1'b1;
              mem_req    <= 1'b0;
              state      <= HOLD;
            end
          end
          HOLD: begin
            if (!dec_stall) begin
              inst_valid <= 1'b0;
              pc         <= dec_next_pc;
              state      <= FETCH;
            end
          end
          DRAIN: begin
            if (mem_ready) begin
              mem_req <= 1'b0;
              state   <= FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher.
module tb_ins_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        dec_stall;
  logic [31:0] dec_next_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        rob_clear;
  logic [31:0] rob_clear_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  ins_fetcher dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .dec_stall    (dec_stall),
    .dec_next_pc  (dec_next_pc),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_addr    (inst_addr),
    .rob_clear    (rob_clear),
    .rob_clear_pc (rob_clear_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all outputs; inst/inst_addr only when a valid instruction is expected.
  task automatic chk_out(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] a, input logic req, input logic [31:0] ma);
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(v));
    if (v) begin
      chk({tag, ".inst"}, inst, i);
      chk({tag, ".inst_addr"}, inst_addr, a);
    end
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(req));
    if (req) chk({tag, ".mem_addr"}, mem_addr, ma);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; dec_stall = 1'b1; dec_next_pc = '0;
    rob_clear = 1'b0; rob_clear_pc = '0; mem_ready = 1'b0; mem_data = '0;
    #3;
    chk("rst.inst_valid", 32'(inst_valid), 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.inst_addr", inst_addr, 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    step(); step();
    rst_in = 1'b0;

    // Cold miss at address 0, memory answers after three cycles.
    step(); chk_out("miss0.req", 1'b0, 0, 0, 1'b1, 32'h0);
    step(); chk_out("miss0.w1", 1'b0, 0, 0, 1'b1, 32'h0);
    step(); chk_out("miss0.w2", 1'b0, 0, 0, 1'b1, 32'h0);
    mem_ready = 1'b1; mem_data = 32'h0000_0013;
    step(); chk_out("miss0.ret", 1'b1, 32'h13, 32'h0, 1'b0, 0);
    mem_ready = 1'b0; mem_data = 32'hdead_beef;

    // Decoder stalls for five cycles.
    for (int k = 0; k < 5; k++) begin
      step(); chk_out("hold", 1'b1, 32'h13, 32'h0, 1'b0, 0);
    end
    dec_stall = 1'b0; dec_next_pc = 32'h4;
    step(); chk_out("consume0", 1'b0, 0, 0, 1'b0, 0);
    dec_stall = 1'b1;
    step(); chk_out("miss4.req", 1'b0, 0, 0, 1'b1, 32'h4);
    mem_ready = 1'b1; mem_data = 32'h0040_0093;
    step(); chk_out("miss4.ret", 1'b1, 32'h0040_0093, 32'h4, 1'b0, 0);
    mem_ready = 1'b0;

    // Refetch of cached address 0: hit two edges after consumption.
    dec_stall = 1'b0; dec_next_pc = 32'h0;
    step(); chk_out("hit0.e1", 1'b0, 0, 0, 1'b0, 0);
    dec_stall = 1'b1;
    step(); chk_out("hit0.e2", 1'b1, 32'h13, 32'h0, 1'b0, 0);

    // Flush during a miss to 8: drain, discard, then fetch 0x100.
    dec_stall = 1'b0; dec_next_pc = 32'h8;
    step(); dec_stall = 1'b1;
    step(); chk_out("miss8.req", 1'b0, 0, 0, 1'b1, 32'h8);
    rob_clear = 1'b1; rob_clear_pc = 32'h100;
    step(); chk_out("drain.e1", 1'b0, 0, 0, 1'b1, 32'h8);
    rob_clear = 1'b0;
    step(); chk_out("drain.e2", 1'b0, 0, 0, 1'b1, 32'h8);
    mem_ready = 1'b1; mem_data = 32'haaaa_0008;
    step(); chk_out("drain.ret", 1'b0, 0, 0, 1'b0, 0);
    mem_ready = 1'b0;
    step(); chk_out("miss100.req", 1'b0, 0, 0, 1'b1, 32'h100);

    // Flush coincident with mem_ready: data cached but not presented.
    rob_clear = 1'b1; rob_clear_pc = 32'h8; mem_ready = 1'b1; mem_data = 32'h1234_0100;
    step(); chk_out("clrret", 1'b0, 0, 0, 1'b0, 0);
    rob_clear = 1'b0; mem_ready = 1'b0;
    step(); chk_out("hit8", 1'b1, 32'haaaa_0008, 32'h8, 1'b0, 0);
    dec_stall = 1'b0; dec_next_pc = 32'h100;
    step(); dec_stall = 1'b1;
    step(); chk_out("hit100", 1'b1, 32'h1234_0100, 32'h100, 1'b0, 0);

    // rdy_in low mid-WAIT freezes state and ignores mem_ready.
    dec_stall = 1'b0; dec_next_pc = 32'hC;
    step(); dec_stall = 1'b1;
    step(); chk_out("missC.req", 1'b0, 0, 0, 1'b1, 32'hC);
    rdy_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 1); mem_data = 32'h5555_000C;
      step(); chk_out("frozen", 1'b0, 0, 0, 1'b1, 32'hC);
    end
    mem_ready = 1'b0; rdy_in = 1'b1;
    step(); chk_out("thaw", 1'b0, 0, 0, 1'b1, 32'hC);

    // Asynchronous reset mid-WAIT.
    #2 rst_in = 1'b1;
    #1;
    chk("arst.inst_valid", 32'(inst_valid), 32'd0);
    chk("arst.inst", inst, 32'd0);
    chk("arst.inst_addr", inst_addr, 32'd0);
    chk("arst.mem_req", 32'(mem_req), 32'd0);
    chk("arst.mem_addr", mem_addr, 32'd0);
    step(); rst_in = 1'b0;
    step(); chk_out("postrst.req", 1'b0, 0, 0, 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
